// File: rtl/mvm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvm_seq_pkg
// Brief    : State encoding, default sizes and address-map helpers for the
//            bit-serial matrix-vector multiply sequencer.
// Revision : 1.0
// ============================================================================
package mvm_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_LOAD_A   = 3'd2,
      ST_LOAD_B   = 3'd3,
      ST_CALC     = 3'd4,
      ST_WRITE    = 3'd5,
      ST_NEXT_ROW = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   localparam int unsigned DEF_N_ROWS = 8;
   localparam int unsigned DEF_N_ELEM = 8;
   localparam int unsigned DEF_N_PE   = 2;
   localparam int unsigned DEF_BIT_W  = 16;
   localparam int unsigned DEF_ADDR_W = 8;

   // Memory map: vector A at 0, matrix rows follow, results after the last row.
   function automatic int unsigned a_base();
      return 0;
   endfunction

   function automatic int unsigned b_row_base(input int unsigned row, input int unsigned n_elem);
      return n_elem * (row + 1);
   endfunction

   function automatic int unsigned out_base(input int unsigned n_elem, input int unsigned n_rows);
      return n_elem * (n_rows + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_seq_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : mvm_seq_addr_gen
// Brief    : Decodes memory address and one-hot PE B-load enable from the
//            sequencer state, row and element counters.
// Revision : 1.0
// ============================================================================
module mvm_seq_addr_gen
   import mvm_seq_pkg::*;
#(
   parameter int unsigned N_ROWS = DEF_N_ROWS,
   parameter int unsigned N_ELEM = DEF_N_ELEM,
   parameter int unsigned N_PE   = DEF_N_PE,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned RW     = 3,
   parameter int unsigned EW     = 3
)(
   input  logic [2:0]        state,
   input  logic [RW-1:0]     row,
   input  logic [EW-1:0]     elem,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [N_PE-1:0]   pe_b_en
);

   localparam int unsigned c_ELEM_PER_PE = N_ELEM / N_PE;

   int unsigned w_addr;
   int unsigned w_pe_sel;

   always_comb begin
      w_addr   = 0;
      w_pe_sel = 32'(elem) / c_ELEM_PER_PE;
      pe_b_en  = '0;
      case (state)
         ST_LOAD_A: w_addr = a_base() + 32'(elem);
         ST_LOAD_B: begin
            w_addr  = b_row_base(32'(row), N_ELEM) + 32'(elem);
            pe_b_en = N_PE'(1) << w_pe_sel;
         end
         ST_WRITE:  w_addr = out_base(N_ELEM, N_ROWS) + 32'(row);
         default:   w_addr = 0;
      endcase
      mem_addr = ADDR_W'(w_addr);
   end

endmodule
`default_nettype wire

// File: rtl/mvm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mvm_seq_ctrl
// Brief    : Row/element/bit sequencer for the bit-serial MVM datapath.
//            Optional cancel input enabled by defining MVM_CTRL_ABORT_EN.
// Revision : 1.0
// ============================================================================
module mvm_seq_ctrl
   import mvm_seq_pkg::*;
#(
   parameter int unsigned N_ROWS = DEF_N_ROWS,
   parameter int unsigned N_ELEM = DEF_N_ELEM,
   parameter int unsigned N_PE   = DEF_N_PE,
   parameter int unsigned BIT_W  = DEF_BIT_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   localparam int unsigned RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef MVM_CTRL_ABORT_EN
   input  logic              abort,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              vec_a_en,
   output logic [N_PE-1:0]   pe_b_en,
   output logic              i_valid,
   output logic              i_is_msb,
   output logic              i_is_lsb,
   output logic              w_data_en,
   output logic              write,
   output logic [RW-1:0]     row_idx
);

   localparam int unsigned EW = $clog2(N_ELEM);
   localparam int unsigned BW = $clog2(BIT_W);
   localparam logic [EW-1:0] c_ELEM_LAST = EW'(N_ELEM - 1);
   localparam logic [BW-1:0] c_BIT_LAST  = BW'(BIT_W - 1);
   localparam logic [RW-1:0] c_ROW_LAST  = RW'(N_ROWS - 1);

   generate
      if ((N_ELEM % N_PE) != 0) begin : g_bad_pe_split
         $error("mvm_seq_ctrl: N_ELEM must be a multiple of N_PE");
      end
   endgenerate

   state_t        r_state, w_state_nxt;
   logic [EW-1:0] r_elem,  w_elem_nxt;
   logic [BW-1:0] r_bit,   w_bit_nxt;
   logic [RW-1:0] r_row,   w_row_nxt;
   logic          w_abort;

`ifdef MVM_CTRL_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_elem  <= '0;
         r_bit   <= '0;
         r_row   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_elem  <= w_elem_nxt;
         r_bit   <= w_bit_nxt;
         r_row   <= w_row_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_elem_nxt  = r_elem;
      w_bit_nxt   = r_bit;
      w_row_nxt   = r_row;
      case (r_state)
         ST_IDLE: begin
            w_elem_nxt = '0;
            w_bit_nxt  = '0;
            w_row_nxt  = '0;
            if (start) w_state_nxt = ST_START;
         end
         ST_START: w_state_nxt = ST_LOAD_A;
         ST_LOAD_A: begin
            if (r_elem == c_ELEM_LAST) begin
               w_elem_nxt  = '0;
               w_state_nxt = ST_LOAD_B;
            end else begin
               w_elem_nxt = r_elem + EW'(1);
            end
         end
         ST_LOAD_B: begin
            if (r_elem == c_ELEM_LAST) begin
               w_elem_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = ST_CALC;
            end else begin
               w_elem_nxt = r_elem + EW'(1);
            end
         end
         ST_CALC: begin
            if (r_bit == c_BIT_LAST) begin
               w_bit_nxt   = '0;
               w_state_nxt = ST_WRITE;
            end else begin
               w_bit_nxt = r_bit + BW'(1);
            end
         end
         ST_WRITE: w_state_nxt = ST_NEXT_ROW;
         ST_NEXT_ROW: begin
            if (r_row == c_ROW_LAST) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_row_nxt   = r_row + RW'(1);
               w_elem_nxt  = '0;
               w_state_nxt = ST_LOAD_B;
            end
         end
         ST_DONE: begin
            // Counters are cleared on the way out so IDLE shows row_idx 0 at once.
            if (!start) begin
               w_state_nxt = ST_IDLE;
               w_elem_nxt  = '0;
               w_bit_nxt   = '0;
               w_row_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_elem_nxt  = '0;
            w_bit_nxt   = '0;
            w_row_nxt   = '0;
         end
      endcase
      if (w_abort && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
         w_elem_nxt  = '0;
         w_bit_nxt   = '0;
         w_row_nxt   = '0;
      end
   end

   always_comb begin
      busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
      done      = (r_state == ST_DONE);
      vec_a_en  = (r_state == ST_LOAD_A);
      i_valid   = (r_state == ST_CALC);
      i_is_msb  = (r_state == ST_CALC) && (r_bit == '0);
      i_is_lsb  = (r_state == ST_CALC) && (r_bit == c_BIT_LAST);
      w_data_en = (r_state == ST_CALC) && (r_bit == c_BIT_LAST);
      write     = (r_state == ST_WRITE);
      row_idx   = r_row;
   end

   mvm_seq_addr_gen #(
      .N_ROWS (N_ROWS),
      .N_ELEM (N_ELEM),
      .N_PE   (N_PE),
      .ADDR_W (ADDR_W),
      .RW     (RW),
      .EW     (EW)
   ) u_addr_gen (
      .state    (r_state),
      .row      (r_row),
      .elem     (r_elem),
      .mem_addr (mem_addr),
      .pe_b_en  (pe_b_en)
   );

endmodule
`default_nettype wire

// File: tb/tb_mvm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvm_seq_ctrl
// Brief    : Directed self-checking bench for mvm_seq_ctrl (default, 4-PE and
//            short single-row configurations).
// Revision : 1.0
// ============================================================================
module tb_mvm_seq_ctrl;

   localparam int NR  = 8;
   localparam int NE  = 8;
   localparam int BWD = 16;
   localparam int LAT = 1 + NE + NR * (NE + BWD + 2);
   localparam int LAT_S = 1 + 8 + 1 * (8 + 4 + 2);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int unsigned exp_q[$];

   // default instance
   logic       start_d, busy_d, done_d, vec_a_en_d, i_valid_d, i_is_msb_d, i_is_lsb_d, w_data_en_d, write_d;
   logic [7:0] mem_addr_d;
   logic [1:0] pe_b_en_d;
   logic [2:0] row_idx_d;
`ifdef MVM_CTRL_ABORT_EN
   logic       abort_d;
`endif
   // four-PE instance
   logic       start_p, busy_p, done_p, vec_a_en_p, i_valid_p, i_is_msb_p, i_is_lsb_p, w_data_en_p, write_p;
   logic [7:0] mem_addr_p;
   logic [3:0] pe_b_en_p;
   logic [2:0] row_idx_p;
   // single-row, 4-bit instance
   logic       start_s, busy_s, done_s, vec_a_en_s, i_valid_s, i_is_msb_s, i_is_lsb_s, w_data_en_s, write_s;
   logic [7:0] mem_addr_s;
   logic [1:0] pe_b_en_s;
   logic [0:0] row_idx_s;

   mvm_seq_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_d),
`ifdef MVM_CTRL_ABORT_EN
      .abort(abort_d),
`endif
      .busy(busy_d), .done(done_d), .mem_addr(mem_addr_d), .vec_a_en(vec_a_en_d),
      .pe_b_en(pe_b_en_d), .i_valid(i_valid_d), .i_is_msb(i_is_msb_d), .i_is_lsb(i_is_lsb_d),
      .w_data_en(w_data_en_d), .write(write_d), .row_idx(row_idx_d)
   );

   mvm_seq_ctrl #(.N_PE(4)) u_pe4 (
      .clk(clk), .rst_n(rst_n), .start(start_p),
`ifdef MVM_CTRL_ABORT_EN
      .abort(1'b0),
`endif
      .busy(busy_p), .done(done_p), .mem_addr(mem_addr_p), .vec_a_en(vec_a_en_p),
      .pe_b_en(pe_b_en_p), .i_valid(i_valid_p), .i_is_msb(i_is_msb_p), .i_is_lsb(i_is_lsb_p),
      .w_data_en(w_data_en_p), .write(write_p), .row_idx(row_idx_p)
   );

   mvm_seq_ctrl #(.N_ROWS(1), .BIT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_s),
`ifdef MVM_CTRL_ABORT_EN
      .abort(1'b0),
`endif
      .busy(busy_s), .done(done_s), .mem_addr(mem_addr_s), .vec_a_en(vec_a_en_s),
      .pe_b_en(pe_b_en_s), .i_valid(i_valid_s), .i_is_msb(i_is_msb_s), .i_is_lsb(i_is_lsb_s),
      .w_data_en(w_data_en_s), .write(write_s), .row_idx(row_idx_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Full default run; hold=1 keeps start high through DONE, tgl=1 wiggles start in CALC.
   task automatic run_dut(input bit hold, input bit tgl);
      int cyc;
      int nwr;
      int unsigned e;
      exp_q.delete();
      for (int r = 0; r < NR; r++) exp_q.push_back(NE * (NR + 1) + r);
      @(negedge clk) start_d = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start_d = 1'b0;
      cyc = 0;
      nwr = 0;
      while (cyc < LAT + 20) begin
         @(posedge clk);
         cyc++;
         #1;
         if (tgl && i_valid_d) start_d = 1'($urandom_range(0, 1));
         if (write_d) begin
            nwr++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            chk("wr_addr", 32'(mem_addr_d), e);
         end
         if (done_d) break;
      end
      chk("done_latency", cyc, LAT);
      chk("write_count", nwr, NR);
      chk("sb_empty", exp_q.size(), 0);
      if (hold) begin
         repeat (3) @(posedge clk);
         #1;
         chk("done_hold", {31'd0, done_d}, 1);
         @(negedge clk) start_d = 1'b0;
         @(posedge clk);
         #1;
         chk("idle_after_done", {busy_d, done_d, row_idx_d}, 0);
      end else begin
         @(negedge clk) start_d = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk("idle_after_pulse", {busy_d, done_d}, 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int cyc;
      int k;
      int nwr;
      logic [3:0] pe_exp [8];
      pe_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
      start_d = 1'b0;
      start_p = 1'b0;
      start_s = 1'b0;
`ifdef MVM_CTRL_ABORT_EN
      abort_d = 1'b0;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs_d", {busy_d, done_d, mem_addr_d, vec_a_en_d, pe_b_en_d, i_valid_d,
                         i_is_msb_d, i_is_lsb_d, w_data_en_d, write_d, row_idx_d}, 0);
      chk("rst_outs_p", {busy_p, done_p, mem_addr_p, pe_b_en_p, write_p, row_idx_p}, 0);
      chk("rst_outs_s", {busy_s, done_s, mem_addr_s, i_valid_s, write_s, row_idx_s}, 0);
      @(negedge clk) rst_n = 1'b1;

      // Defaults, start held high
      run_dut(1'b1, 1'b0);

      // Start pulsed, then toggled during CALC
      run_dut(1'b0, 1'b1);

      // Four PEs: one-hot B-load sequence for row 0
      @(negedge clk) start_p = 1'b1;
      cyc = 0;
      while (cyc < 40 && pe_b_en_p == '0) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("pe4_b_en[%0d]", i), 32'(pe_b_en_p), 32'(pe_exp[i]));
         chk($sformatf("pe4_b_addr[%0d]", i), 32'(mem_addr_p), 8 + i);
         @(posedge clk);
         #1;
      end
      start_p = 1'b0;
      cyc = 0;
      while (cyc < LAT + 20 && !done_p) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      chk("pe4_done", {31'd0, done_p}, 1);

      // Single row, BIT_W=4
      exp_q.delete();
      exp_q.push_back(16);
      @(negedge clk) start_s = 1'b1;
      @(posedge clk);
      cyc = 0;
      k = 0;
      nwr = 0;
      while (cyc < 60) begin
         @(posedge clk);
         cyc++;
         #1;
         if (i_valid_s) begin
            k++;
            chk($sformatf("small_msb[%0d]", k), {31'd0, i_is_msb_s}, (k == 1) ? 1 : 0);
            chk($sformatf("small_lsb[%0d]", k), {30'd0, i_is_lsb_s, w_data_en_s}, (k == 4) ? 3 : 0);
         end
         if (write_s) begin
            nwr++;
            chk("small_wr_addr", 32'(mem_addr_s), (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
         end
         if (done_s) break;
      end
      chk("small_calc_cycles", k, 4);
      chk("small_writes", nwr, 1);
      chk("small_latency", cyc, LAT_S);
      @(negedge clk) start_s = 1'b0;

      // Reset in the 5th CALC cycle of row 3
      @(negedge clk) start_d = 1'b1;
      cyc = 0;
      k = 0;
      while (cyc < LAT && k < 5) begin
         @(posedge clk);
         cyc++;
         #1;
         if (row_idx_d == 3'd3 && i_valid_d) k++;
      end
      chk("mid_rst_reached", k, 5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {busy_d, done_d, mem_addr_d, vec_a_en_d, pe_b_en_d, i_valid_d,
                           i_is_msb_d, i_is_lsb_d, w_data_en_d, write_d, row_idx_d}, 0);
      start_d = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_hold", {busy_d, done_d, write_d}, 0);
      @(negedge clk) rst_n = 1'b1;
      run_dut(1'b1, 1'b0);

`ifdef MVM_CTRL_ABORT_EN
      // Abort during LOAD_B of row 2
      @(negedge clk) start_d = 1'b1;
      @(posedge clk);
      #1;
      start_d = 1'b0;
      cyc = 0;
      while (cyc < LAT && !(row_idx_d == 3'd2 && pe_b_en_d != '0)) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      chk("abort_point", {busy_d, row_idx_d}, {1'b1, 3'd2});
      abort_d = 1'b1;
      @(posedge clk);
      #1;
      abort_d = 1'b0;
      chk("abort_idle", {busy_d, done_d, row_idx_d, mem_addr_d}, 0);
      nwr = 0;
      k = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (write_d) nwr++;
         if (done_d || busy_d) k++;
      end
      chk("abort_no_write", nwr, 0);
      chk("abort_stays_idle", k, 0);
      run_dut(1'b1, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Parametrised sequencing controller for the bit-serial matrix-vector multiply datapath: loads vector A once, then, for each matrix row, loads B elements across N_PE processing elements, runs BIT_W bit-serial cycles, and writes one result word. Unlike the fixed 8x8/2-PE/16-bit controller, it owns its own row, element and bit counters, generates memory addresses itself and drives a one-hot PE load bus. It sits between the top-level start/done handshake and the PE array plus shared memory.

## Interface
- N_ROWS, 8, matrix rows (>=1)
- N_ELEM, 8, elements per row / vector length (>=2)
- N_PE, 2, processing elements; N_ELEM % N_PE == 0 required (elaboration error otherwise)
- BIT_W, 16, bit-serial cycles per row (>=2)
- ADDR_W, 8, memory address width; must hold N_ELEM*(N_ROWS+1)+N_ROWS-1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level request
- abort  in  1  cancel (present only with MVM_CTRL_ABORT_EN)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- mem_addr  out  ADDR_W  read/write address
- vec_a_en  out  1  capture read data into vector A register
- pe_b_en  out  N_PE  one-hot B-load enable
- i_valid, i_is_msb, i_is_lsb  out  1 each  bit-serial PE controls
- w_data_en  out  1  capture PE result
- write  out  1  memory write strobe
- row_idx  out  $clog2(N_ROWS) (min 1)  current row

## Operation
- States: IDLE, START, LOAD_A, LOAD_B, CALC, WRITE, NEXT_ROW, DONE.
- IDLE: start=1 -> START; element, bit and row counters cleared.
- START: one idle cycle -> LOAD_A.
- LOAD_A: N_ELEM cycles, vec_a_en=1, mem_addr=e (e = element counter 0..N_ELEM-1); at e=N_ELEM-1 -> LOAD_B, e cleared.
- LOAD_B: N_ELEM cycles, mem_addr=N_ELEM*(r+1)+e; pe_b_en bit (e / (N_ELEM/N_PE)) set; at e=N_ELEM-1 -> CALC, bit counter cleared.
- CALC: BIT_W cycles, i_valid=1; i_is_msb at bit 0, i_is_lsb and w_data_en at bit BIT_W-1, then -> WRITE.
- WRITE: write=1, mem_addr=N_ELEM*(N_ROWS+1)+r -> NEXT_ROW.
- NEXT_ROW: r==N_ROWS-1 -> DONE; else r++, e cleared -> LOAD_B.
- DONE: done=1 held while start=1; start=0 -> IDLE. A still-high start never relaunches.
- start ignored in every state except IDLE and DONE.
- All address arithmetic unsigned, truncated to ADDR_W; outputs default 0 in every state unless listed above.

## Timing
- Reset (asynchronous, rst_n=0): state IDLE, all counters 0, every output 0 (mem_addr 0, pe_b_en 0, row_idx 0).
- Reset mid-operation: immediate return to IDLE; no write strobe completes; done stays 0.
- All control outputs decoded from the registered state and counters (Moore); no input-to-output combinational path except none.
- Latency: done rises 1+N_ELEM+N_ROWS*(N_ELEM+BIT_W+2) rising edges after the edge sampling start=1 in IDLE (217 at defaults).
- Counters wrap only via explicit clear; the element counter never exceeds N_ELEM-1 and the bit counter never exceeds BIT_W-1.

## Configuration
- MVM_CTRL_ABORT_EN defined: abort port exists; abort=1 in any state other than IDLE forces IDLE on the next edge, clears all counters, suppresses write and done; abort has priority over all transitions; abort in IDLE is ignored.
- Undefined: no abort port; operation runs to DONE unless reset.

## Structure
- Package mvm_seq_pkg: state enumeration, default parameter constants, address-base helper functions (A base, B row base, output base).
- One sub-module, mvm_seq_addr_gen: computes mem_addr and pe_b_en from state, row and element counters.

## Test plan
- Defaults, start pulse held high: done rises after 217 edges; exactly 8 write strobes at addresses 72..79; done stays high until start=0, then IDLE.
- N_PE=4, N_ELEM=8: pe_b_en per LOAD_B sequence 0001,0001,0010,0010,0100,0100,1000,1000.
- BIT_W=4, N_ROWS=1: i_is_msb on first CALC cycle, i_is_lsb with w_data_en on fourth; single write to address 16; done after 1+8+14=23 edges.
- rst_n low in the 5th CALC cycle of row 3: all outputs 0 immediately; restart completes normally with 8 writes.
- MVM_CTRL_ABORT_EN, abort in LOAD_B of row 2: IDLE next edge, no further write, done never rises; next start completes normally.
- start toggled high during CALC: no effect on sequence or latency.
